// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline stages.
package canny_pkg;

  // Quantised gradient direction codes produced by the angle quantiser.
  localparam logic [1:0] ANG_0   = 2'd0;
  localparam logic [1:0] ANG_45  = 2'd1;
  localparam logic [1:0] ANG_90  = 2'd2;
  localparam logic [1:0] ANG_135 = 2'd3;

  localparam int DEF_MAG_W = 12;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } nms_state_t;

endpackage

// File: rtl/nms_line_buffer.sv
// One-line circular delay buffer. Reads are combinational at the shared
// address, so the value returned is the one written a full line earlier
// (read-before-write). Contents are deliberately left unreset.
module nms_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  // Store the incoming word at the current column.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/canny_nms_stage.sv
// Non-maximum suppression over a 3x3 magnitude window built from two line
// buffers. Output is delayed by one line plus one pixel; a flush phase
// drains the last IMG_W+1 centers of each frame.
//
// state    | meaning
// ST_FILL  | accepting first IMG_W+1 pixels, no output yet
// ST_RUN   | one output per accepted pixel
// ST_FLUSH | input blocked, zero pixels shifted for IMG_W+1 cycles
module canny_nms_stage
  import canny_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MAG_W = DEF_MAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [1:0]       in_angle,
  output logic             out_valid,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_W);

  nms_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, ccol_q, ccol_d;
  logic [RW-1:0] row_q, row_d, crow_q, crow_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;

  // Window columns: index 0 = west, 1 = center, 2 = east.
  logic [2:0][MAG_W-1:0] win_t_q, win_t_d;
  logic [2:0][MAG_W-1:0] win_m_q, win_m_d;
  logic [2:0][MAG_W-1:0] win_b_q, win_b_d;
  logic [1:0] ang_r_q, ang_r_d, ang_c_q, ang_c_d;

  logic             out_valid_q, out_last_q;
  logic [MAG_W-1:0] out_mag_q;

  logic             accept, shift, emit, border, keep;
  logic [MAG_W-1:0] new_mag, ctr_mag, prev_mag, next_mag;
  logic [1:0]       new_ang;
  logic [MAG_W+1:0] mid_rd;
  logic [MAG_W-1:0] top_rd;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = in_valid && in_ready;
  assign shift    = accept || (state_q == ST_FLUSH);
  assign emit     = shift && (state_q != ST_FILL);
  assign new_mag  = (state_q == ST_FLUSH) ? '0 : in_mag;
  assign new_ang  = (state_q == ST_FLUSH) ? ANG_0 : in_angle;

  // Middle row carries angle; the north row never needs its angle so the
  // second buffer holds magnitude only.
  nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(MAG_W + 2), .ADDR_W(CW)) u_lb_mid (
    .clk       (clk),
    .we_i      (shift),
    .addr_i    (col_q),
    .wr_data_i ({new_mag, new_ang}),
    .rd_data_o (mid_rd)
  );

  nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(MAG_W), .ADDR_W(CW)) u_lb_top (
    .clk       (clk),
    .we_i      (shift),
    .addr_i    (col_q),
    .wr_data_i (mid_rd[MAG_W+1:2]),
    .rd_data_o (top_rd)
  );

  // Next window contents and the suppression decision on the new center.
  always_comb begin
    win_t_d  = {top_rd, win_t_q[2:1]};
    win_m_d  = {mid_rd[MAG_W+1:2], win_m_q[2:1]};
    win_b_d  = {new_mag, win_b_q[2:1]};
    ang_r_d  = mid_rd[1:0];
    ang_c_d  = ang_r_q;
    ctr_mag  = win_m_d[1];
    prev_mag = win_m_d[0];
    next_mag = win_m_d[2];
    case (ang_c_d)
      ANG_0:   begin prev_mag = win_m_d[0]; next_mag = win_m_d[2]; end
      ANG_45:  begin prev_mag = win_t_d[2]; next_mag = win_b_d[0]; end
      ANG_90:  begin prev_mag = win_t_d[1]; next_mag = win_b_d[1]; end
      default: begin prev_mag = win_t_d[0]; next_mag = win_b_d[2]; end
    endcase
    border = (ccol_q == '0) || (ccol_q == COL_LAST) ||
             (crow_q == '0) || (crow_q == ROW_LAST);
    // Strict on the earlier neighbour, inclusive on the later one, so a
    // flat pair keeps only its first pixel.
    keep   = !border && (ctr_mag > prev_mag) && (ctr_mag >= next_mag);
  end

  // Next-state logic for phase, raster counters and flush down-counter.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    ccol_d      = ccol_q;
    crow_d      = crow_q;
    flush_cnt_d = flush_cnt_q;
    if (shift) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (emit) begin
      if (ccol_q == COL_LAST) begin
        ccol_d = '0;
        crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + RW'(1);
      end else begin
        ccol_d = ccol_q + CW'(1);
      end
    end
    case (state_q)
      ST_FILL: begin
        if (accept && (row_q == RW'(1)) && (col_q == '0)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_FILL;
          col_d   = '0;
          row_d   = '0;
          ccol_d  = '0;
          crow_d  = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Phase, counters and window registers; the window only moves on a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      col_q       <= '0;
      row_q       <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      flush_cnt_q <= '0;
      win_t_q     <= '0;
      win_m_q     <= '0;
      win_b_q     <= '0;
      ang_r_q     <= '0;
      ang_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ccol_q      <= ccol_d;
      crow_q      <= crow_d;
      flush_cnt_q <= flush_cnt_d;
      if (shift) begin
        win_t_q <= win_t_d;
        win_m_q <= win_m_d;
        win_b_q <= win_b_d;
        ang_r_q <= ang_r_d;
        ang_c_q <= ang_c_d;
      end
    end
  end

  // Registered output pixel, one pulse per emitted center.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= emit;
      out_mag_q   <= (emit && keep) ? ctr_mag : '0;
      out_last_q  <= emit && (state_q == ST_FLUSH) && (flush_cnt_q == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_canny_nms_stage.sv
// Directed bench for the NMS stage on an 8x6 frame with a per-pixel
// reference built straight from the image array.
module tb_canny_nms_stage;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_mag;
  logic [1:0]  in_angle;
  logic        out_valid;
  logic [11:0] out_mag;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;

  logic [11:0] img_mag [N];
  logic [1:0]  img_ang [N];
  logic [11:0] q_mag [$];
  logic        q_last [$];

  canny_nms_stage #(.IMG_W(W), .IMG_H(H), .MAG_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_mag   (out_mag),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      q_mag.push_back(out_mag);
      q_last.push_back(out_last);
    end
    if (!in_ready) low_cnt++;
  end

  function automatic logic [11:0] pix(input int r, input int c);
    return img_mag[r * W + c];
  endfunction

  function automatic logic [11:0] ref_out(input int i);
    int r, c;
    logic [11:0] ctr, p, n;
    r = i / W;
    c = i % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 12'd0;
    ctr = img_mag[i];
    case (img_ang[i])
      2'd0:    begin p = pix(r, c - 1);     n = pix(r, c + 1);     end
      2'd1:    begin p = pix(r - 1, c + 1); n = pix(r + 1, c - 1); end
      2'd2:    begin p = pix(r - 1, c);     n = pix(r + 1, c);     end
      default: begin p = pix(r - 1, c - 1); n = pix(r + 1, c + 1); end
    endcase
    return (ctr > p && ctr >= n) ? ctr : 12'd0;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < N; i++) begin
      img_mag[i] = 12'd0;
      img_ang[i] = 2'd0;
    end
  endtask

  task automatic send_pixel(input logic [11:0] m, input logic [1:0] a, input int gap_pct);
    int t;
    t = 0;
    if (gap_pct > 0) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_mag   = m;
    in_angle = a;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input string tag, input int n);
    int t;
    t = 0;
    while (q_mag.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    assert (q_mag.size() == n) else begin
      errors++;
      $error("FAIL %s out_count got %0d expected %0d", tag, q_mag.size(), n);
    end
  endtask

  task automatic check_frame(input string tag);
    int m;
    m = (q_mag.size() < N) ? q_mag.size() : N;
    for (int i = 0; i < m; i++) begin
      checks++;
      assert (q_mag[i] === ref_out(i)) else begin
        errors++;
        $error("FAIL %s mag px %0d got %0d expected %0d", tag, i, q_mag[i], ref_out(i));
      end
      checks++;
      assert (q_last[i] === (i == N - 1)) else begin
        errors++;
        $error("FAIL %s last px %0d got %0b expected %0b", tag, i, q_last[i], (i == N - 1));
      end
    end
    checks++;
    assert (low_cnt == W + 1) else begin
      errors++;
      $error("FAIL %s ready_low_cycles got %0d expected %0d", tag, low_cnt, W + 1);
    end
  endtask

  // early9: confirm nothing comes out while the first W+1 pixels fill.
  task automatic run_frame(input string tag, input int gap_pct, input bit early9);
    q_mag.delete();
    q_last.delete();
    low_cnt = 0;
    for (int i = 0; i < N; i++) begin
      send_pixel(img_mag[i], img_ang[i], gap_pct);
      if (early9 && i == W) begin
        @(negedge clk);
        checks++;
        assert (q_mag.size() == 0) else begin
          errors++;
          $error("FAIL %s early_output got %0d expected 0", tag, q_mag.size());
        end
        @(posedge clk); #1;
      end
    end
    wait_outputs(tag, N);
    check_frame(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_mag   = 12'd0;
    in_angle = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready got %0b expected 1", in_ready); end
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid got %0b expected 0", out_valid); end
    checks++;
    assert (out_mag === 12'd0) else begin errors++; $error("FAIL rst_out_mag got %0d expected 0", out_mag); end
    checks++;
    assert (out_last === 1'b0) else begin errors++; $error("FAIL rst_out_last got %0b expected 0", out_last); end
    rst = 1'b0;
    @(posedge clk); #1;

    // Flat field: every interior center ties its west neighbour.
    for (int i = 0; i < N; i++) begin
      img_mag[i] = 12'd100;
      img_ang[i] = 2'd0;
    end
    run_frame("flat", 0, 1'b0);

    // Vertical ridge at column 3.
    for (int i = 0; i < N; i++) begin
      img_mag[i] = (i % W == 3) ? 12'd200 : 12'd50;
      img_ang[i] = 2'd0;
    end
    run_frame("ridge", 0, 1'b0);

    // Diagonal 45 deg: center (2,2), NE (1,3), SW (3,1).
    clear_img();
    img_mag[2 * W + 2] = 12'd300;
    img_ang[2 * W + 2] = 2'd1;
    img_mag[1 * W + 3] = 12'd299;
    img_mag[3 * W + 1] = 12'd299;
    run_frame("diag45", 0, 1'b0);

    // Same window, 135 deg with a larger NW neighbour.
    img_ang[2 * W + 2] = 2'd3;
    img_mag[1 * W + 1] = 12'd400;
    run_frame("diag135", 0, 1'b0);

    // Plateau pair in row 2.
    clear_img();
    img_mag[2 * W + 3] = 12'd500;
    img_mag[2 * W + 4] = 12'd500;
    run_frame("plateau", 0, 1'b0);

    // Random frame with input gaps.
    for (int i = 0; i < N; i++) begin
      img_mag[i] = 12'($urandom_range(0, 4095));
      img_ang[i] = 2'($urandom_range(0, 3));
    end
    run_frame("gaps", 40, 1'b0);

    // Abort a frame after 20 pixels, then a clean frame.
    for (int i = 0; i < 20; i++) send_pixel(12'd777, 2'd0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_out_valid got %0b expected 0", out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      img_mag[i] = 12'($urandom_range(0, 4095));
      img_ang[i] = 2'($urandom_range(0, 3));
    end
    run_frame("after_rst", 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
